// File: rtl/conv_codec_pkg.sv
// -----------------------------------------------------------------------------
// conv_codec_pkg
// Shared definitions for the convolutional codec frame controller:
//   - state_t     : frame sequencer states
//   - tail_len()  : number of zero tail bits that flush a constraint-length-K
//                   encoder back to the all-zero trellis state
//   - cnt_width() : width of the shared tail/traceback down-counter
// -----------------------------------------------------------------------------
package conv_codec_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TAIL  = 3'd2,
        TRACE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // K-1 zero bits drive every encoder shift-register stage back to zero.
    function automatic int tail_len(input int k);
        return k - 1;
    endfunction

    // Wide enough to hold max(K-1, TB_DEPTH); never narrower than one bit.
    function automatic int cnt_width(input int k, input int tb_depth);
        int max_val;
        max_val = ((k - 1) > tb_depth) ? (k - 1) : tb_depth;
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/conv_ctrl_cnt.sv
// -----------------------------------------------------------------------------
// conv_ctrl_cnt
// Loadable down-counter with zero flag. Shared by the tail-bit and traceback
// phases of the frame controller. Load has priority over decrement; the count
// saturates at zero rather than wrapping.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (count -> 0)
//   load        : load load_val this cycle
//   load_val    : value to load
//   dec         : decrement by one (ignored when count is already zero)
//   count       : current count
//   zero        : count == 0
// -----------------------------------------------------------------------------
module conv_ctrl_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    // NOTE: registers are updated with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/conv_codec_frame_ctrl.sv
// -----------------------------------------------------------------------------
// conv_codec_frame_ctrl
// Frame sequencer for the convolutional encoder / Viterbi decoder datapath.
// Accepts a frame command, passes cmd_len payload bits through to the codec
// (one per handshake), appends K-1 zero tail bits to terminate the trellis,
// runs TB_DEPTH traceback steps, then pulses done for one cycle.
//
// Parameters:
//   K        : constraint length (tail length K-1)
//   LEN_W    : width of the payload bit count
//   TB_DEPTH : traceback cycles per frame (>= 1)
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   abort                      : frame abort (only with CONV_CTRL_ABORT_EN)
//   cmd_valid/cmd_ready/cmd_len: frame command handshake and payload length
//   in_valid/in_ready/in_bit   : payload bit stream from host
//   sym_valid/sym_ready/sym_bit: bit stream into the codec
//   sym_tail                   : current codec bit is a tail bit
//   tb_step/tb_first           : decoder traceback step enable / first step
//   busy                       : controller not idle
//   done                       : one-cycle frame completion pulse
//   bit_cnt                    : payload bits transferred in current frame
//
// Build option:
//   CONV_CTRL_ABORT_EN : adds the abort input. abort in any non-IDLE state
//                        returns to IDLE without a done pulse; abort in IDLE
//                        blocks command acceptance.
// -----------------------------------------------------------------------------
module conv_codec_frame_ctrl
    import conv_codec_pkg::*;
#(
    parameter int K        = 3,
    parameter int LEN_W    = 12,
    parameter int TB_DEPTH = 15
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef CONV_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic             sym_bit,
    output logic             sym_tail,
    output logic             tb_step,
    output logic             tb_first,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] bit_cnt
);

    localparam int CW = cnt_width(K, TB_DEPTH);

    // The counter is loaded with (length - 1) so the zero flag marks the last
    // cycle of a phase; that lets the phase exit on zero without a compare.
    localparam logic [CW-1:0] TAIL_LOAD  = CW'(tail_len(K) - 1);
    localparam logic [CW-1:0] TRACE_LOAD = CW'(TB_DEPTH - 1);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bit_cnt_next;
    logic             abort_act;
    logic             load_xfer;

    logic             cnt_load;
    logic [CW-1:0]    cnt_val;
    logic             cnt_dec;
    logic [CW-1:0]    cnt_q;
    logic             cnt_zero;

`ifdef CONV_CTRL_ABORT_EN
    assign abort_act = abort;
`else
    assign abort_act = 1'b0;
`endif

    assign bit_cnt_next = bit_cnt + 1'b1;
    assign load_xfer    = (state == LOAD) && in_valid && sym_ready && !abort_act;

    conv_ctrl_cnt #(
        .W (CW)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (cnt_q),
        .zero     (cnt_zero)
    );

    // Output decode and counter control. Outputs are decoded from the state
    // register alone, except the LOAD-phase handshake which passes through.
    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        sym_valid = 1'b0;
        sym_bit   = 1'b0;
        sym_tail  = 1'b0;
        tb_step   = 1'b0;
        tb_first  = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        cnt_load  = 1'b0;
        cnt_val   = TAIL_LOAD;
        cnt_dec   = 1'b0;

        case (state)
            IDLE: begin
                cmd_ready = !abort_act;
                // Tail length is armed at accept; LOAD never touches the counter.
                if (cmd_valid && !abort_act) begin
                    cnt_load = 1'b1;
                    cnt_val  = TAIL_LOAD;
                end
            end
            LOAD: begin
                sym_valid = in_valid && !abort_act;
                sym_bit   = in_bit;
                in_ready  = sym_ready && !abort_act;
            end
            TAIL: begin
                sym_valid = !abort_act;
                sym_tail  = 1'b1;
                if (sym_ready) begin
                    if (cnt_zero) begin
                        cnt_load = 1'b1;
                        cnt_val  = TRACE_LOAD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            TRACE: begin
                tb_step  = 1'b1;
                tb_first = (cnt_q == TRACE_LOAD);
                cnt_dec  = !cnt_zero;
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            len_q   <= '0;
            bit_cnt <= '0;
        end else if (abort_act && (state != IDLE)) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        len_q   <= cmd_len;
                        bit_cnt <= '0;
                        state   <= (cmd_len == '0) ? TAIL : LOAD;
                    end
                end
                LOAD: begin
                    if (load_xfer) begin
                        bit_cnt <= bit_cnt_next;
                        if (bit_cnt_next == len_q) begin
                            state <= TAIL;
                        end
                    end
                end
                TAIL: begin
                    if (sym_ready && cnt_zero) begin
                        state <= TRACE;
                    end
                end
                TRACE: begin
                    if (cnt_zero) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
